// File: rtl/temporal_encoder.sv
// temporal_encoder: turns per-channel binary values into pulse-width-coded
// spikes aligned to a free-running gamma cycle. One vector can wait in a
// pending register while the previous one is replayed from the active
// register. The replay FSM is two-state: IDLE (nothing to replay this gamma
// cycle) and ACTIVE (active register drives spikes for the whole cycle).
//
// Handshake: a vector transfers on a rising edge where in_valid && in_ready.
// in_val/in_null are captured at that edge. in_ready is a registered copy of
// "pending register empty" (forced low in reset). in_valid may drop at any
// time without a transfer.
module temporal_encoder #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_CH            = 2,
    localparam int VAL_W            = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                      aclk,
    input  logic                      grst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CH*VAL_W-1:0]   in_val,
    input  logic [NUM_CH-1:0]         in_null,
    output logic [NUM_CH-1:0]         spike,
    output logic                      gamma_start,
    output logic                      busy
);

    localparam int VW1 = VAL_W + 1;
    localparam logic [VAL_W-1:0] LAST_SLOT = VAL_W'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [VAL_W:0]   PW_EXT    = VW1'(PULSE_WIDTH);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // run distinguishes the first cycle after reset (slot 0) from normal counting
    logic                    run;
    logic [VAL_W-1:0]        slot,      slot_nxt;
    logic                    pend_full, pend_full_nxt;
    logic [NUM_CH*VAL_W-1:0] pend_val,  pend_val_nxt;
    logic [NUM_CH-1:0]       pend_null, pend_null_nxt;
    state_t                  state,     state_nxt;
    logic [NUM_CH*VAL_W-1:0] act_val,   act_val_nxt;
    logic [NUM_CH-1:0]       act_null,  act_null_nxt;
    logic [NUM_CH-1:0]       spike_nxt;
    logic                    fire;
    logic                    wrap;

    assign fire = in_valid && in_ready;
    assign wrap = run && (slot == LAST_SLOT);

    // Next-state logic: slot counter, pending/active registers and FSM state
    always_comb begin
        slot_nxt      = slot;
        pend_full_nxt = pend_full;
        pend_val_nxt  = pend_val;
        pend_null_nxt = pend_null;
        state_nxt     = state;
        act_val_nxt   = act_val;
        act_null_nxt  = act_null;

        if (!run) begin
            slot_nxt = '0;
        end else if (wrap) begin
            slot_nxt = '0;
        end else begin
            slot_nxt = slot + 1'b1;
        end

        if (wrap) begin
            if (pend_full) begin
                // queued vector takes over for the next gamma cycle
                state_nxt     = ACTIVE;
                act_val_nxt   = pend_val;
                act_null_nxt  = pend_null;
                pend_full_nxt = 1'b0;
            end else if (fire) begin
                // bypass: vector arriving on the last slot goes straight to active
                state_nxt    = ACTIVE;
                act_val_nxt  = in_val;
                act_null_nxt = in_null;
            end else begin
                state_nxt = IDLE;
            end
        end else if (fire) begin
            pend_full_nxt = 1'b1;
            pend_val_nxt  = in_val;
            pend_null_nxt = in_null;
        end
    end

    // Per-channel pulse window: slots t..t+PW-1, never the guard slot, t>=G-1 is null
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [VAL_W-1:0] t;
        logic [VAL_W:0]   t_end;
        assign t     = act_val_nxt[i*VAL_W +: VAL_W];
        assign t_end = {1'b0, t} + PW_EXT;
        assign spike_nxt[i] = (state_nxt == ACTIVE) && !act_null_nxt[i]
                              && (t < LAST_SLOT)
                              && (slot_nxt >= t)
                              && ({1'b0, slot_nxt} < t_end)
                              && (slot_nxt != LAST_SLOT);
    end

    // State and output registers; outputs are computed from next state so they align with slot
    always_ff @(posedge aclk) begin
        if (grst) begin
            run         <= 1'b0;
            slot        <= '0;
            pend_full   <= 1'b0;
            pend_val    <= '0;
            pend_null   <= '0;
            state       <= IDLE;
            act_val     <= '0;
            act_null    <= '0;
            in_ready    <= 1'b0;
            spike       <= '0;
            gamma_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            run         <= 1'b1;
            slot        <= slot_nxt;
            pend_full   <= pend_full_nxt;
            pend_val    <= pend_val_nxt;
            pend_null   <= pend_null_nxt;
            state       <= state_nxt;
            act_val     <= act_val_nxt;
            act_null    <= act_null_nxt;
            in_ready    <= !pend_full_nxt;
            spike       <= spike_nxt;
            gamma_start <= (slot_nxt == '0);
            busy        <= (state_nxt == ACTIVE);
        end
    end

endmodule

// File: tb/tb_temporal_encoder.sv
// Bench for temporal_encoder (G=16, PW=8, 2 channels). A frame-level model
// predicts the whole 16-slot spike/busy pattern of each gamma cycle; a
// monitor captures each gamma cycle from the DUT and compares.
module tb_temporal_encoder;
    localparam int G  = 16;
    localparam int PW = 8;
    localparam int FW = 3 * G;   // per slot: {busy, spike[1], spike[0]}

    logic       aclk = 1'b0;
    logic       grst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_val = '0;
    logic [1:0] in_null = '0;
    logic [1:0] spike;
    logic       gamma_start;
    logic       busy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [FW-1:0] exp_q[$];

    temporal_encoder #(
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH(PW),
        .NUM_CH(2)
    ) dut (
        .aclk(aclk),
        .grst(grst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_val(in_val),
        .in_null(in_null),
        .spike(spike),
        .gamma_start(gamma_start),
        .busy(busy)
    );

    // clock
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected frame straight from the pulse rules: slots t..min(t+PW-1,G-2)
    function automatic logic [FW-1:0] mk_frame(input bit act, input logic [7:0] v, input logic [1:0] nl);
        logic [FW-1:0] f;
        f = '0;
        for (int s = 0; s < G; s++) begin
            f[s*3+2] = act;
            for (int ch = 0; ch < 2; ch++) begin
                int t;
                int last;
                t = int'(v[ch*4 +: 4]);
                last = t + PW - 1;
                if (last > G - 2) last = G - 2;
                if (act && !nl[ch] && t <= G - 2 && s >= t && s <= last)
                    f[s*3+ch] = 1'b1;
            end
        end
        return f;
    endfunction

    // Reference model: tracks gamma slots, one-deep pending queue, and decides each frame
    bit         m_run = 1'b0;
    bit         m_rst_last = 1'b1;
    bit         m_ready = 1'b0;
    int         m_slot = 0;
    logic [7:0] pq_val[$];
    logic [1:0] pq_null[$];

    always @(posedge aclk) begin
        if (grst) begin
            m_rst_last = 1'b1;
            m_run = 1'b0;
            m_slot = 0;
            pq_val.delete();
            pq_null.delete();
            exp_q.delete();
            m_ready = 1'b0;
        end else begin
            m_rst_last = 1'b0;
            if (!m_run) begin
                m_run = 1'b1;
                m_slot = 0;
                exp_q.push_back(mk_frame(1'b0, 8'h00, 2'b00));
            end else if (m_slot == G - 1) begin
                if (pq_val.size() > 0)
                    exp_q.push_back(mk_frame(1'b1, pq_val.pop_front(), pq_null.pop_front()));
                else if (in_valid && m_ready)
                    exp_q.push_back(mk_frame(1'b1, in_val, in_null));
                else
                    exp_q.push_back(mk_frame(1'b0, 8'h00, 2'b00));
                m_slot = 0;
            end else begin
                if (in_valid && m_ready) begin
                    pq_val.push_back(in_val);
                    pq_null.push_back(in_null);
                end
                m_slot++;
            end
            m_ready = (pq_val.size() == 0);
        end
    end

    // Monitor: per-cycle handshake/reset checks, frame capture and compare
    int            cap_n = -1;
    logic [FW-1:0] cap = '0;

    always @(negedge aclk) begin
        if (chk_en) begin
            check("in_ready", FW'(in_ready), FW'(m_ready));
            if (m_rst_last) begin
                check("reset_outputs", FW'({gamma_start, busy, spike}), '0);
                cap_n = -1;
            end else begin
                check("gamma_start", FW'(gamma_start), FW'((cap_n == -1) || (cap_n == G)));
                if (gamma_start) cap_n = 0;
                if (cap_n >= 0 && cap_n < G) begin
                    cap[cap_n*3 +: 3] = {busy, spike};
                    cap_n++;
                    if (cap_n == G) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL frame: got %0h with no expected frame queued", cap);
                        end else begin
                            check("frame", cap, exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic wait_slot(input int s);
        int n;
        n = 0;
        do begin
            @(posedge aclk);
            #1;
            n++;
        end while (!(m_run && m_slot == s) && n < 200);
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_slot: slot %0d not reached in 200 cycles (got %0d)", s, m_slot);
        end
    endtask

    // Holds in_valid until a transfer; leaves in_valid high for back-to-back use
    task automatic send(input logic [3:0] v0, input logic [3:0] v1, input logic [1:0] nl);
        int  n;
        bit  r;
        in_valid = 1'b1;
        in_val   = {v1, v0};
        in_null  = nl;
        n = 0;
        r = 1'b0;
        while (!r && n < 200) begin
            @(negedge aclk);
            r = in_ready;
            @(posedge aclk);
            #1;
            n++;
        end
        checks++;
        if (!r) begin
            errors++;
            $display("FAIL send: in_ready got 0 expected 1 within 200 cycles");
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    // Reset and stimulus
    initial begin
        grst = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk_en = 1'b1;
        @(posedge aclk);
        #1;
        grst = 1'b0;

        // idle gamma cycles
        idle(48);

        // two channels at 2 and 4
        wait_slot(3);
        send(4'd2, 4'd4, 2'b00);
        idle(20);

        // truncation at guard slot, ch1 null; then t=15 gives nothing
        send(4'd10, 4'd0, 2'b10);
        idle(1);
        send(4'd15, 4'd5, 2'b00);
        idle(34);

        // back-to-back with held valid
        wait_slot(2);
        send(4'd1, 4'd1, 2'b00);
        send(4'd2, 4'd2, 2'b00);
        send(4'd3, 4'd3, 2'b00);
        idle(40);

        // equal values tie; then bypass on the last slot
        send(4'd3, 4'd3, 2'b00);
        idle(18);
        wait_slot(G - 1);
        send(4'd0, 4'd14, 2'b00);
        idle(34);

        // reset mid-replay with a pending vector
        wait_slot(3);
        send(4'd1, 4'd6, 2'b00);
        idle(1);
        wait_slot(2);
        send(4'd7, 4'd8, 2'b00);
        in_valid = 1'b0;
        wait_slot(5);
        grst = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        grst = 1'b0;
        idle(40);

        // random traffic, including valid pulses that may not transfer
        for (int c = 0; c < 900; c++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_val   = 8'($urandom);
            in_null  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (c == 450) grst = 1'b1;
            if (c == 453) grst = 1'b0;
            @(posedge aclk);
            #1;
        end
        idle(40);

        check("final_queue_depth", FW'(exp_q.size() <= 1), FW'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
